// File: rtl/led_out_pkg.sv
// ---------------------------------------------------------------------------
// led_out_pkg
//   Shared definitions for the LED driver output stages.
//   - DEFAULT_DATA_WIDTH   : default number of bits per word sent to the chain
//   - DEFAULT_LATCH_CYCLES : default number of clk cycles the latch pulse lasts
//   - led_shift_state_t    : state encoding of the serial shifter FSM
// ---------------------------------------------------------------------------
package led_out_pkg;

  localparam int DEFAULT_DATA_WIDTH   = 16;
  localparam int DEFAULT_LATCH_CYCLES = 2;

  // IDLE  : waiting for a word, o_ready high
  // ALIGN : word captured, waiting for the next divided-clock fall
  // SHIFT : one bit per divided-clock period, sclk gated on
  // LATCH : latch pulse to the drivers after the last word of a frame
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    SHIFT = 2'd2,
    LATCH = 2'd3
  } led_shift_state_t;

endpackage

// File: rtl/div_clk_edge_detect.sv
// ---------------------------------------------------------------------------
// div_clk_edge_detect
//   Detects rising and falling transitions of a divided clock that is itself
//   produced in the clk domain (so no synchroniser is needed).
//   Ports:
//     clk     - system clock
//     rst     - synchronous active-high reset, clears the history bit
//     div_clk - divided clock, registered in the clk domain upstream
//     rise    - one-cycle pulse, div_clk went 0 -> 1
//     fall    - one-cycle pulse, div_clk went 1 -> 0
// ---------------------------------------------------------------------------
module div_clk_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic div_clk,
  output logic rise,
  output logic fall
);

  logic div_prev;

  // History bit: the value of div_clk seen on the previous clk edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_prev <= 1'b0;
    end else begin
      div_prev <= div_clk;
    end
  end

  // Pulses are combinational so the consumer acts on the same edge at which
  // the history bit catches up with the new level.
  assign rise = ~div_prev & div_clk;
  assign fall = div_prev & ~div_clk;

endmodule

// File: rtl/led_shift_out.sv
// ---------------------------------------------------------------------------
// led_shift_out
//   Serialises words MSB first onto an LED driver chain using a gated copy of
//   a divided clock, and pulses the driver latch after the last word of a
//   frame.
//   Parameters:
//     DATA_WIDTH   - bits per word (>= 2)
//     LATCH_CYCLES - clk cycles the latch pulse stays high (>= 1)
//   Ports:
//     clk       - system clock
//     rst       - synchronous active-high reset
//     i_div_clk - divided clock (even division >= 4) generated in clk domain
//     i_data    - word to shift, MSB first
//     i_last    - marks the final word of a frame; latch follows it
//     i_valid   - i_data / i_last are valid
//     o_ready   - word accepted when i_valid & o_ready
//     o_sclk    - gated serial clock to the drivers
//     o_sdata   - serial data to the drivers
//     o_latch   - driver latch pulse
//     o_busy    - high whenever the FSM is not idle
// ---------------------------------------------------------------------------
module led_shift_out
  import led_out_pkg::*;
#(
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int LATCH_CYCLES = DEFAULT_LATCH_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_div_clk,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_last,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic                  o_sclk,
  output logic                  o_sdata,
  output logic                  o_latch,
  output logic                  o_busy
);

  localparam int CNT_W  = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam int LCNT_W = $clog2(LATCH_CYCLES + 1);

  led_shift_state_t     state, state_n;
  logic [DATA_WIDTH-1:0] shreg, shreg_n;
  logic [CNT_W-1:0]     bit_cnt, bit_cnt_n;
  logic [LCNT_W-1:0]    latch_cnt, latch_cnt_n;
  logic                 last_flag, last_n;
  logic                 sclk_q, sclk_n;
  logic                 sdata_q, sdata_n;
  logic                 latch_q, latch_n;

  logic                 div_rise;
  logic                 div_fall;

  div_clk_edge_detect u_edge (
    .clk     (clk),
    .rst     (rst),
    .div_clk (i_div_clk),
    .rise    (div_rise),
    .fall    (div_fall)
  );

  // Only falling edges move data; rising edges are left to the gated sclk.
  // The two pulses are mutually exclusive by construction of the detector.
  always_comb begin
    assert (!(div_rise && div_fall));
  end

  // Next-state and next-datapath logic. Data changes on a divided-clock fall
  // so that the drivers, which sample on sclk rising, always see a settled bit
  // half a divided period later.
  always_comb begin
    state_n     = state;
    shreg_n     = shreg;
    bit_cnt_n   = bit_cnt;
    latch_cnt_n = latch_cnt;
    last_n      = last_flag;
    sdata_n     = sdata_q;

    case (state)
      IDLE: begin
        if (i_valid) begin
          shreg_n   = i_data;
          last_n    = i_last;
          bit_cnt_n = CNT_W'(DATA_WIDTH - 1);
          state_n   = ALIGN;
        end
      end

      ALIGN: begin
        // First bit goes out on a fall so the first sclk high phase is a
        // full half period, never a runt.
        if (div_fall) begin
          sdata_n = shreg[DATA_WIDTH-1];
          state_n = SHIFT;
        end
      end

      SHIFT: begin
        if (div_fall) begin
          if (bit_cnt != '0) begin
            shreg_n   = {shreg[DATA_WIDTH-2:0], 1'b0};
            bit_cnt_n = bit_cnt - CNT_W'(1);
            sdata_n   = shreg[DATA_WIDTH-2];
          end else if (last_flag) begin
            latch_cnt_n = LCNT_W'(LATCH_CYCLES - 1);
            state_n     = LATCH;
          end else begin
            state_n = IDLE;
          end
        end
      end

      LATCH: begin
        if (latch_cnt == '0) begin
          state_n = IDLE;
        end else begin
          latch_cnt_n = latch_cnt - LCNT_W'(1);
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    // sclk is the divided clock delayed one clk and gated by SHIFT. Because
    // the FSM leaves SHIFT on the same edge that sclk loads a low level,
    // exactly DATA_WIDTH high phases escape per word.
    sclk_n  = i_div_clk & (state == SHIFT);
    latch_n = (state_n == LATCH);
  end

  // State and datapath registers; reset discards any partial word at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      latch_cnt <= '0;
      last_flag <= 1'b0;
      sclk_q    <= 1'b0;
      sdata_q   <= 1'b0;
      latch_q   <= 1'b0;
    end else begin
      state     <= state_n;
      shreg     <= shreg_n;
      bit_cnt   <= bit_cnt_n;
      latch_cnt <= latch_cnt_n;
      last_flag <= last_n;
      sclk_q    <= sclk_n;
      sdata_q   <= sdata_n;
      latch_q   <= latch_n;
    end
  end

  assign o_ready = (state == IDLE);
  assign o_busy  = (state != IDLE);
  assign o_sclk  = sclk_q;
  assign o_sdata = sdata_q;
  assign o_latch = latch_q;

endmodule

// File: tb/tb_led_shift_out.sv
// ---------------------------------------------------------------------------
// tb_led_shift_out
//   Bench for led_shift_out with DATA_WIDTH=16, LATCH_CYCLES=2 and a divide-
//   by-10 clock source. Words are issued by applyStimulus, which pushes the
//   expected serial bits (and latch event) into a scoreboard queue; a monitor
//   pops and compares on every sclk rise and latch pulse.
// ---------------------------------------------------------------------------
module tb_led_shift_out;

  localparam int DW       = 16;
  localparam int LC       = 2;
  localparam int DIV_HALF = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          div_q;
  logic [3:0]    div_cnt;
  logic          div_hold = 1'b0;
  logic          i_div_clk;
  logic [DW-1:0] i_data = '0;
  logic          i_last = 1'b0;
  logic          i_valid = 1'b0;
  logic          o_ready;
  logic          o_sclk;
  logic          o_sdata;
  logic          o_latch;
  logic          o_busy;

  typedef struct packed {
    logic is_latch;
    logic value;
  } exp_t;

  exp_t exp_q[$];

  int   total_checks = 0;
  int   pass_checks  = 0;
  int   violations   = 0;
  int   rise_count   = 0;
  int   latch_run    = 0;
  logic sclk_prev    = 1'b0;
  logic sdata_prev   = 1'b0;
  logic latch_prev   = 1'b0;

  always #5 clk = ~clk;

  // Divide-by-10 clock source, registered in the clk domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= 4'd0;
      div_q   <= 1'b0;
    end else if (div_cnt == 4'(DIV_HALF - 1)) begin
      div_cnt <= 4'd0;
      div_q   <= ~div_q;
    end else begin
      div_cnt <= div_cnt + 4'd1;
    end
  end

  // div_hold freezes the divided clock low to stall the aligner.
  assign i_div_clk = div_q & ~div_hold;

  led_shift_out #(
    .DATA_WIDTH   (DW),
    .LATCH_CYCLES (LC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_div_clk (i_div_clk),
    .i_data    (i_data),
    .i_last    (i_last),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .o_sclk    (o_sclk),
    .o_sdata   (o_sdata),
    .o_latch   (o_latch),
    .o_busy    (o_busy)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total_checks++;
    if (actual === expected) begin
      pass_checks++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic pushWord(input logic [DW-1:0] data, input logic last, input int nbits);
    exp_t e;
    for (int i = 0; i < nbits; i++) begin
      e.is_latch = 1'b0;
      e.value    = data[DW-1-i];
      exp_q.push_back(e);
    end
    if (last && nbits == DW) begin
      e.is_latch = 1'b1;
      e.value    = 1'b0;
      exp_q.push_back(e);
    end
  endtask

  // Called at a negedge. Holds i_valid until the DUT shows o_ready; the word
  // is taken on the following posedge, at which point expectations are queued.
  task automatic applyStimulus(input logic [DW-1:0] data, input logic last,
                               input int nbits);
    bit accepted = 1'b0;
    i_data  = data;
    i_last  = last;
    i_valid = 1'b1;
    for (int n = 0; n < 3000 && !accepted; n++) begin
      if (o_ready) begin
        pushWord(data, last, nbits);
        accepted = 1'b1;
        @(posedge clk);
      end
      @(negedge clk);
    end
    i_valid = 1'b0;
    if (!accepted) begin
      total_checks++;
      $display("[TB] FAIL accept_timeout: word 0x%0h never accepted, expected acceptance", data);
    end
  endtask

  task automatic waitDone(input string name);
    bit done = 1'b0;
    for (int n = 0; n < 3000 && !done; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !o_busy && !o_latch) done = 1'b1;
    end
    if (!done) begin
      total_checks++;
      $display("[TB] FAIL %s_timeout: %0d events pending, busy=%0b, expected drained",
               name, exp_q.size(), o_busy);
    end
    repeat (3) @(negedge clk);
  endtask

  // Monitor and protocol checker, sampling on the inactive clock edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sclk_prev  = 1'b0;
      sdata_prev = o_sdata;
      latch_prev = 1'b0;
      latch_run  = 0;
    end else begin
      if (sclk_prev && o_sclk && (o_sdata != sdata_prev)) begin
        violations++;
        $display("[TB] protocol violation: sdata changed while sclk high");
      end
      if (o_sclk && (o_latch || !o_busy)) begin
        violations++;
        $display("[TB] protocol violation: sclk high outside shifting");
      end

      if (o_sclk && !sclk_prev) begin
        rise_count++;
        if (exp_q.size() == 0) begin
          total_checks++;
          $display("[TB] FAIL unexpected_sclk: rise with sdata=%0b, expected no rise", o_sdata);
        end else begin
          e = exp_q.pop_front();
          checkOutput("serial_bit", {30'd0, 1'b0, o_sdata}, {30'd0, e.is_latch, e.value});
        end
      end

      if (o_latch) begin
        if (!latch_prev) begin
          if (exp_q.size() == 0) begin
            total_checks++;
            $display("[TB] FAIL unexpected_latch: latch rose, expected no latch");
          end else begin
            e = exp_q.pop_front();
            checkOutput("latch_event", {30'd0, 2'b10}, {30'd0, e.is_latch, e.value});
          end
        end
        latch_run++;
      end else if (latch_prev) begin
        checkOutput("latch_width", 32'(latch_run), 32'(LC));
        latch_run = 0;
      end

      sclk_prev  = o_sclk;
      sdata_prev = o_sdata;
      latch_prev = o_latch;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    bit seen;

    // Reset values.
    rst = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("rst_sclk",  32'(o_sclk),  32'd0);
    checkOutput("rst_sdata", 32'(o_sdata), 32'd0);
    checkOutput("rst_latch", 32'(o_latch), 32'd0);
    checkOutput("rst_busy",  32'(o_busy),  32'd0);
    checkOutput("rst_ready", 32'(o_ready), 32'd1);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Single last word: 1010010111000011 then a 2-cycle latch.
    $display("[TB] word 0xA5C3 with latch");
    applyStimulus(16'hA5C3, 1'b1, DW);
    waitDone("a5c3");
    checkOutput("ready_after_latch", 32'(o_ready), 32'd1);

    // Two words back to back, latch only after the second.
    $display("[TB] 0x1234 then 0xFFFF");
    applyStimulus(16'h1234, 1'b0, DW);
    applyStimulus(16'hFFFF, 1'b1, DW);
    waitDone("b2b");

    // Second word presented while the first is still shifting.
    $display("[TB] 0x0F0F held during shifting of 0x8001");
    applyStimulus(16'h8001, 1'b1, DW);
    fork
      applyStimulus(16'h0F0F, 1'b1, DW);
      begin
        repeat (60) @(negedge clk);
        checkOutput("ready_low_in_shift", 32'(o_ready), 32'd0);
        checkOutput("busy_in_shift",      32'(o_busy),  32'd1);
      end
    join
    waitDone("held");

    // Reset after five sclk rises of 0xA5C3: only five bits may appear.
    $display("[TB] abort 0xA5C3 after five bits");
    base = rise_count;
    applyStimulus(16'hA5C3, 1'b1, 5);
    seen = 1'b0;
    for (int n = 0; n < 2000 && !seen; n++) begin
      @(negedge clk);
      if (rise_count >= base + 5) seen = 1'b1;
    end
    if (!seen) begin
      total_checks++;
      $display("[TB] FAIL abort_wait: %0d rises, expected 5", rise_count - base);
    end
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_sclk",  32'(o_sclk),  32'd0);
    checkOutput("abort_latch", 32'(o_latch), 32'd0);
    checkOutput("abort_busy",  32'(o_busy),  32'd0);
    checkOutput("abort_ready", 32'(o_ready), 32'd1);
    checkOutput("abort_sdata", 32'(o_sdata), 32'd0);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    checkOutput("abort_no_more_rises", 32'(rise_count), 32'(base + 5));
    checkOutput("abort_queue_empty",   32'(exp_q.size()), 32'd0);

    // Divided clock frozen low after acceptance: FSM must wait in ALIGN.
    $display("[TB] divided clock stalled low");
    seen = 1'b0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk);
      if (!i_div_clk) seen = 1'b1;
    end
    div_hold = 1'b1;
    base = rise_count;
    applyStimulus(16'h3C5A, 1'b1, DW);
    repeat (40) @(negedge clk);
    checkOutput("stall_busy",     32'(o_busy),     32'd1);
    checkOutput("stall_sclk",     32'(o_sclk),     32'd0);
    checkOutput("stall_ready",    32'(o_ready),    32'd0);
    checkOutput("stall_no_rises", 32'(rise_count), 32'(base));
    div_hold = 1'b0;
    waitDone("stall");

    checkOutput("protocol_violations", 32'(violations),   32'd0);
    checkOutput("scoreboard_empty",    32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_checks, total_checks);
    $finish;
  end

endmodule

// File: doc/led_shift_out.md
LED_SHIFT_OUT -- requirements
Module: led_shift_out

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, bits per word shifted to the LED driver chain (>=2).
REQ-002 The block SHALL have parameter LATCH_CYCLES, default 2, clk cycles o_latch stays high (>=1).
REQ-003 The block SHALL have port clk, input, 1, the single system clock.
REQ-004 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port i_div_clk, input, 1, the divided clock from clk_divider, generated in the clk domain with an even FACTOR >= 4.
REQ-006 The block SHALL have port i_data, input, DATA_WIDTH, the word to shift, MSB first.
REQ-007 The block SHALL have port i_last, input, 1, high to mark the final word of a frame (latch after it).
REQ-008 The block SHALL have port i_valid, input, 1, meaning i_data/i_last are valid.
REQ-009 The block SHALL have port o_ready, output, 1, meaning a word is accepted on i_valid & o_ready.
REQ-010 The block SHALL have port o_sclk, output, 1, the gated serial clock to the drivers.
REQ-011 The block SHALL have port o_sdata, output, 1, the serial data to the drivers.
REQ-012 The block SHALL have port o_latch, output, 1, the driver latch pulse.
REQ-013 The block SHALL have port o_busy, output, 1, high whenever state != IDLE.

Function
REQ-014 The block SHALL keep a 1-bit register div_prev that loads i_div_clk every cycle; fall = div_prev & ~i_div_clk.
REQ-015 The block SHALL use states IDLE, ALIGN, SHIFT, LATCH.
REQ-016 IDLE: o_ready=1; on i_valid & o_ready, the block SHALL capture i_data into the shift register, capture i_last, set bit_cnt=DATA_WIDTH-1 and go to ALIGN.
REQ-017 ALIGN: o_ready=0; on fall, the block SHALL set o_sdata to shreg MSB and go to SHIFT; with no fall it stays in ALIGN indefinitely.
REQ-018 SHIFT: on fall with bit_cnt != 0, the block SHALL shift left, decrement bit_cnt and drive the next bit on o_sdata.
REQ-019 SHIFT: on fall with bit_cnt == 0, the block SHALL go to LATCH if the captured last=1, else to IDLE; o_sdata holds.
REQ-020 The o_sclk register SHALL load i_div_clk & (state==SHIFT) every cycle.
REQ-021 As a result, o_sclk SHALL lag i_div_clk by one clk, o_sdata SHALL change only on the clk edge where o_sclk goes low, and exactly DATA_WIDTH o_sclk rising edges SHALL occur per word.
REQ-022 LATCH: the block SHALL hold o_latch=1 for exactly LATCH_CYCLES cycles (down-counter) with o_sclk=0, then go to IDLE.
REQ-023 i_valid asserted while o_ready=0 SHALL be ignored; the word is not captured until IDLE.
REQ-024 The block SHALL place no bubble between IDLE and ALIGN beyond one cycle; consecutive non-last words realign to the next fall.
REQ-025 The block SHALL ignore i_div_clk rising events for data purposes; only fall advances state.

Reset
REQ-026 When rst is sampled high, the block SHALL go to IDLE and clear shreg, bit_cnt, latch counter, last flag and div_prev.
REQ-027 Outputs after reset SHALL be: o_sclk=0, o_sdata=0, o_latch=0, o_busy=0, o_ready=1.
REQ-028 rst asserted mid-SHIFT or mid-LATCH SHALL abort immediately (next edge), with no further sclk or latch pulses and the partial word discarded.

Structure
REQ-029 Package led_out_pkg SHALL hold the state enum led_shift_state_t and the default DATA_WIDTH/LATCH_CYCLES constants.
REQ-030 The fall detection SHALL be one sub-module, div_clk_edge_detect (outputs rise/fall pulses), so it can be reused by other driver stages.
REQ-031 Everything else SHALL be flat, single always_ff plus combinational next-state.

Verification (bench instantiates clk_divider FACTOR=10 feeding i_div_clk, DATA_WIDTH=16, LATCH_CYCLES=2)
REQ-032 Word 0xA5C3 with last=1 -> 16 o_sclk rises; bits sampled on rises = 1010010111000011; then o_latch high exactly 2 cycles; o_ready=1 afterwards.
REQ-033 0x1234 last=0 then 0xFFFF last=1 back-to-back -> 32 o_sclk rises, first 16 bits = 0x1234, no latch between words, one 2-cycle latch after bit 32.
REQ-034 i_valid held high with 0x0F0F during SHIFT of a prior word -> o_ready=0 and no capture until IDLE, then 0x0F0F shifted intact.
REQ-035 rst pulsed after 5 sclk rises of 0xA5C3 -> next cycle o_sclk=0, o_latch=0, o_busy=0, o_ready=1; no latch ever asserted for that word.
REQ-036 i_div_clk forced to 0 after word accepted -> block stays in ALIGN, o_sclk=0, o_busy=1; on release, shifting completes normally.
REQ-037 A checker SHALL flag any o_sdata change while o_sclk=1 and any o_sclk activity outside SHIFT.
